// File: rtl/csa_pkg.sv
// Shared types and helpers for the carry-save resolver.
// Operand weights: sum bit i weighs 2^i, carry bit i weighs 2^(i+1).
package csa_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } csa_state_e;

    localparam int CARRY_WEIGHT_SHIFT = 1;

    function automatic int chunk_count(input int width, input int chunk);
        return width / chunk;
    endfunction

endpackage

// File: rtl/csa_chunk_adder.sv
// CHUNK-bit ripple adder assembled from single-bit full-adder cells.
// Purely combinational; the resolver instantiates one of these in its datapath.
module csa_full_adder (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);
    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (ci & (a ^ b));
endmodule

module csa_chunk_adder #(
    parameter int CHUNK = 2
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             cin,
    output logic [CHUNK-1:0] sum,
    output logic             cout
);
    logic [CHUNK:0] c;

    assign c[0] = cin;

    for (genvar i = 0; i < CHUNK; i++) begin : g_fa
        csa_full_adder u_fa (
            .a  (a[i]),
            .b  (b[i]),
            .ci (c[i]),
            .s  (sum[i]),
            .co (c[i+1])
        );
    end

    assign cout = c[CHUNK];
endmodule

// File: rtl/csa_resolver.sv
// Resolves a {sum, carry} pair to binary with a chunked, multi-cycle carry-propagate add.
// Optional out_ovf port is enabled by defining CSA_RESOLVER_OVF_EN.
//
// state | meaning
// IDLE  | in_ready high, waiting for an operand pair
// RUN   | resolving one CHUNK-bit slice per cycle, carry held between slices
// DONE  | out_valid high, result held until out_ready
module csa_resolver
    import csa_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CHUNK = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_sum,
    input  logic [WIDTH-1:0] in_carry,
    output logic             out_valid,
    input  logic             out_ready,
`ifdef CSA_RESOLVER_OVF_EN
    output logic             out_ovf,
`endif
    output logic [WIDTH+1:0] out_result
);

    localparam int NCH  = chunk_count(WIDTH, CHUNK);
    localparam int IDXW = (NCH > 1) ? $clog2(NCH) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NCH - 1);

    csa_state_e        state_q, state_d;
    logic [IDXW-1:0]   idx_q, idx_d;
    logic              carry_q, carry_d;
    // A's two top bits are always zero, so only the live bits are stored;
    // B is held pre-shifted by the carry weight, its top bit is B[WIDTH].
    logic [WIDTH-1:0]  a_q, a_d;
    logic [WIDTH:0]    b_q, b_d;
    logic [WIDTH+1:0]  result_q, result_d;

    logic [CHUNK-1:0]  chunk_a, chunk_b, chunk_sum;
    logic              chunk_cout;

    csa_chunk_adder #(.CHUNK(CHUNK)) u_adder (
        .a    (chunk_a),
        .b    (chunk_b),
        .cin  (carry_q),
        .sum  (chunk_sum),
        .cout (chunk_cout)
    );

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        carry_d  = carry_q;
        a_d      = a_q;
        b_d      = b_q;
        result_d = result_q;
        chunk_a  = '0;
        chunk_b  = '0;

        for (int i = 0; i < NCH; i++) begin
            if (idx_q == IDXW'(i)) begin
                chunk_a = a_q[i*CHUNK +: CHUNK];
                chunk_b = b_q[i*CHUNK +: CHUNK];
            end
        end

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = in_sum;
                    b_d     = {in_carry, 1'b0} << (CARRY_WEIGHT_SHIFT - 1);
                    idx_d   = '0;
                    carry_d = 1'b0;
                    state_d = RUN;
                end
            end
            RUN: begin
                for (int i = 0; i < NCH; i++) begin
                    if (idx_q == IDXW'(i)) begin
                        result_d[i*CHUNK +: CHUNK] = chunk_sum;
                    end
                end
                carry_d = chunk_cout;
                idx_d   = idx_q + IDXW'(1);
                if (idx_q == LAST_IDX) begin
                    result_d[WIDTH+1:WIDTH] = {1'b0, chunk_cout} + {1'b0, b_q[WIDTH]};
                    idx_d   = '0;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            carry_q  <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            carry_q  <= carry_d;
            a_q      <= a_d;
            b_q      <= b_d;
            result_q <= result_d;
        end
    end

`ifdef CSA_RESOLVER_OVF_EN
    logic ovf_q, ovf_d;

    always_comb begin
        ovf_d = ovf_q;
        if (state_q == RUN && idx_q == LAST_IDX) begin
            ovf_d = |result_d[WIDTH+1:WIDTH];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign out_ovf = ovf_q;
`endif

    assign in_ready   = (state_q == IDLE);
    assign out_valid  = (state_q == DONE);
    assign out_result = result_q;

endmodule
